fusion_avg_stream: RTL and testbench

Streaming N-frame temporal-average fusion engine, the parametrised successor to the first-generation fusion top. It accepts the newest frame I(n) and the aged-out frame I(n−N) as two AXI-Stream inputs and keeps a per-pixel running sum in on-chip RAM. It emits the per-pixel average of the last N frames as an AXI-Stream output. It sits between the DDR read DMA (two channels) and the DDR write DMA.

---
 rtl/fusion_avg_stream.sv | 165 ++++++++++++++++
 tb/tb_fusion_avg_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fusion_avg_stream.sv
// Streaming N-frame temporal average: per-pixel running sum in block RAM, average of last 2^LOG2_FRAMES frames out.
// Optional macro FUSION_ROUND_EN selects round-half-up averaging instead of truncation.
module fusion_avg_stream #(
  parameter int PIX_W       = 8,
  parameter int LANES       = 16,
  parameter int LOG2_FRAMES = 4,
  parameter int FRAME_BEATS = 16900
) (
  input  logic                   s_axis_clk,
  input  logic                   s_axis_aresetn,
  input  logic [PIX_W*LANES-1:0] s_new_tdata,
  input  logic                   s_new_tvalid,
  output logic                   s_new_tready,
  input  logic                   s_new_tlast,
  input  logic [PIX_W*LANES-1:0] s_old_tdata,
  input  logic                   s_old_tvalid,
  output logic                   s_old_tready,
  input  logic                   s_old_tlast,
  output logic [PIX_W*LANES-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  input  logic                   flush,
  output logic                   fill_done,
  output logic                   err_tlast
);

  localparam int ACC_W = PIX_W + LOG2_FRAMES;
  localparam int DW    = PIX_W * LANES;
  localparam int AW    = ACC_W * LANES;
  localparam int BW    = $clog2(FRAME_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                 state;
  logic [LOG2_FRAMES-1:0] frame;
  logic [BW-1:0]          beat;
  logic                   flush_pend;
  logic                   live;

  logic en, flush_now, run_eff, first_eff, emit_eff, beat_last, accept, tlast_bad;

  // live keeps every tready low until the first clock after reset release
  assign en        = live & ~(m_axis_tvalid & ~m_axis_tready);
  assign flush_now = (flush | flush_pend) & (beat == '0);
  assign run_eff   = (state == RUN) & ~flush_now;
  assign first_eff = ~run_eff & (flush_now | (frame == '0));
  assign emit_eff  = run_eff | (~flush_now & (frame == '1));
  assign beat_last = (beat == LAST_BEAT);

  assign s_new_tready = en & (~run_eff | s_old_tvalid);
  assign s_old_tready = en & run_eff & s_new_tvalid;
  assign accept       = en & s_new_tvalid & (~run_eff | s_old_tvalid);
  assign tlast_bad    = (s_new_tlast != beat_last) | (run_eff & (s_old_tlast != beat_last));
  assign fill_done    = (state == RUN);

  always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state      <= FILL;
      frame      <= '0;
      beat       <= '0;
      flush_pend <= 1'b0;
      live       <= 1'b0;
      err_tlast  <= 1'b0;
    end else begin
      live <= 1'b1;
      if (flush_now) begin
        state      <= FILL;
        frame      <= '0;
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
      // flush_now implies beat 0, so it never collides with the frame-end update
      if (accept) begin
        if (tlast_bad) err_tlast <= 1'b1;
        if (beat_last) begin
          beat <= '0;
          if (!run_eff) begin
            if (frame == '1) begin
              state <= RUN;
              frame <= '0;
            end else begin
              frame <= frame + 1'b1;
            end
          end
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

  logic          s1_valid, s1_first, s1_run, s1_emit, s1_last;
  logic [BW-1:0] s1_addr;
  logic [DW-1:0] s1_new, s1_old;

  always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_run   <= 1'b0;
      s1_emit  <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s1_new   <= '0;
      s1_old   <= '0;
    end else if (en) begin
      s1_valid <= accept;
      s1_first <= first_eff;
      s1_run   <= run_eff;
      s1_emit  <= emit_eff;
      s1_last  <= beat_last;
      s1_addr  <= beat;
      s1_new   <= s_new_tdata;
      s1_old   <= s_old_tdata;
    end
  end

  logic [AW-1:0] acc_ram [FRAME_BEATS];
  logic [AW-1:0] rd_data;
  logic [AW-1:0] acc_next;
  logic [DW-1:0] avg_bus;

  // Read and write addresses coincide only FRAME_BEATS beats apart, so no bypass is needed
  always_ff @(posedge s_axis_clk) begin
    if (en) rd_data <= acc_ram[beat];
    if (en & s1_valid) acc_ram[s1_addr] <= acc_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ACC_W-1:0] acc_q, pix_new, pix_old, acc_nx;
      assign acc_q   = rd_data[gi*ACC_W +: ACC_W];
      assign pix_new = ACC_W'(s1_new[gi*PIX_W +: PIX_W]);
      assign pix_old = s1_run ? ACC_W'(s1_old[gi*PIX_W +: PIX_W]) : '0;
      // Intermediate wrap is harmless: the true sum always fits ACC_W bits
      assign acc_nx  = s1_first ? pix_new : (acc_q + pix_new - pix_old);
      assign acc_next[gi*ACC_W +: ACC_W] = acc_nx;
`ifdef FUSION_ROUND_EN
      localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (LOG2_FRAMES - 1);
      assign avg_bus[gi*PIX_W +: PIX_W] = PIX_W'(({1'b0, acc_nx} + HALF) >> LOG2_FRAMES);
`else
      assign avg_bus[gi*PIX_W +: PIX_W] = PIX_W'(acc_nx >> LOG2_FRAMES);
`endif
    end
  endgenerate

  always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (en) begin
      m_axis_tvalid <= s1_valid & s1_emit;
      if (s1_valid & s1_emit) begin
        m_axis_tdata <= avg_bus;
        m_axis_tlast <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_fusion_avg_stream.sv
// Scoreboard bench for fusion_avg_stream: 2 lanes x 8 bits, 4-frame average, 4-beat frames.
module tb_fusion_avg_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] s_new_tdata, s_old_tdata, m_axis_tdata;
  logic        s_new_tvalid, s_new_tready, s_new_tlast;
  logic        s_old_tvalid, s_old_tready, s_old_tlast;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        flush, fill_done, err_tlast;

  fusion_avg_stream #(.PIX_W(8), .LANES(2), .LOG2_FRAMES(2), .FRAME_BEATS(4)) dut (
    .s_axis_clk(clk), .s_axis_aresetn(rst_n),
    .s_new_tdata(s_new_tdata), .s_new_tvalid(s_new_tvalid), .s_new_tready(s_new_tready), .s_new_tlast(s_new_tlast),
    .s_old_tdata(s_old_tdata), .s_old_tvalid(s_old_tvalid), .s_old_tready(s_old_tready), .s_old_tlast(s_old_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .flush(flush), .fill_done(fill_done), .err_tlast(err_tlast)
  );

`ifdef FUSION_ROUND_EN
  localparam int RND = 2;
`else
  localparam int RND = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          stamp;
  } exp_t;

  exp_t        outq[$];
  logic [63:0] hist[$];
  int          cyc = 0;
  bit          lat_mode = 0;
  bit          rnd_ready = 0;

  // Reference model state
  int  m_acc [4][2];
  bit  m_run, m_pend, exp_err;
  int  m_frame, m_beat;

  always @(negedge clk) begin : monitor
    bit   fn, new_hs, old_hs, first, emit, last_b;
    int   nv, ov;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      outq.delete();
      m_run = 0; m_pend = 0; exp_err = 0; m_frame = 0; m_beat = 0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        $display("out beat data=%h last=%b t=%0d", m_axis_tdata, m_axis_tlast, cyc);
        if (outq.size() == 0) begin
          check_eq("out_unexpected", 32'(outq.size()), 32'd1);
        end else begin
          e = outq.pop_front();
          check_eq("out_data", 32'(m_axis_tdata), 32'(e.data));
          check_eq("out_last", 32'(m_axis_tlast), 32'(e.last));
          if (lat_mode) check_eq("latency", cyc - e.stamp, 32'd2);
        end
      end
      fn = (flush || m_pend) && (m_beat == 0);
      if (fn) begin
        m_run = 0; m_frame = 0; m_pend = 0;
      end else if (flush) begin
        m_pend = 1;
      end
      new_hs = s_new_tvalid && s_new_tready;
      old_hs = s_old_tvalid && s_old_tready;
      if (new_hs) begin
        check_eq("old_lockstep", 32'(old_hs), 32'(m_run));
        last_b = (m_beat == 3);
        first  = !m_run && (m_frame == 0);
        emit   = m_run || (m_frame == 3);
        e.last  = last_b;
        e.stamp = cyc;
        for (int l = 0; l < 2; l++) begin
          nv = int'(s_new_tdata[l*8 +: 8]);
          ov = int'(s_old_tdata[l*8 +: 8]);
          if (first) m_acc[m_beat][l] = nv;
          else if (m_run) m_acc[m_beat][l] = (m_acc[m_beat][l] + nv - ov) & 1023;
          else m_acc[m_beat][l] = (m_acc[m_beat][l] + nv) & 1023;
          e.data[l*8 +: 8] = 8'((m_acc[m_beat][l] + RND) >> 2);
        end
        if (emit) outq.push_back(e);
        if ((s_new_tlast != last_b) || (m_run && (s_old_tlast != last_b))) exp_err = 1;
        if (last_b) begin
          m_beat = 0;
          if (!m_run) begin
            if (m_frame == 3) begin m_run = 1; m_frame = 0; end
            else m_frame++;
          end
        end else begin
          m_beat++;
        end
      end else if (old_hs) begin
        check_eq("old_alone", 32'(old_hs), 32'd0);
      end
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic drive_beat(input logic [15:0] nd, input logic [15:0] od,
                            input logic nl, input logic ol, input int gap);
    int c = 0;
    int nd_dly = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
    int od_dly = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
    s_new_tdata = nd; s_new_tlast = nl;
    s_old_tdata = od; s_old_tlast = ol;
    forever begin
      s_new_tvalid = (c >= nd_dly);
      s_old_tvalid = (c >= od_dly);
      @(negedge clk);
      if (s_new_tvalid && s_new_tready) break;
      if (c > 300) begin
        check_eq("accept_timeout", 32'(s_new_tready), 32'd1);
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    @(posedge clk); #1;
    s_new_tvalid = 1'b0;
    s_old_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] fr, input int gap, input int bad_beat, input int flush_beat);
    logic [63:0] od;
    int h = hist.size();
    od = (h >= 4) ? hist[h-4] : 64'hA5A5_5A5A_C3C3_3C3C;
    for (int b = 0; b < 4; b++) begin
      if (b == flush_beat) begin
        flush = 1'b1;
        fork begin @(posedge clk); #1; flush = 1'b0; end join_none
      end
      drive_beat(fr[b*16 +: 16], od[b*16 +: 16], (b == 3) ^ (b == bad_beat), b == 3, gap);
      if (b == bad_beat) check_eq("err_tlast_set", 32'(err_tlast), 32'd1);
    end
    hist.push_back(fr);
  endtask

  function automatic logic [63:0] const_frame(input logic [7:0] v);
    return {4{v, v}};
  endfunction

  function automatic logic [63:0] rand_frame();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = 8'($urandom_range(255, 0));
    return f;
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 100 && outq.size() != 0; i++) @(negedge clk);
    check_eq("drain", 32'(outq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] fill_vals [4];
    rst_n = 1'b0; flush = 1'b0;
    s_new_tdata = '0; s_new_tvalid = 1'b0; s_new_tlast = 1'b0;
    s_old_tdata = '0; s_old_tvalid = 1'b0; s_old_tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_new_tready", 32'(s_new_tready), 32'd0);
    check_eq("rst_old_tready", 32'(s_old_tready), 32'd0);
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("rst_fill_done", 32'(fill_done), 32'd0);
    check_eq("rst_err_tlast", 32'(err_tlast), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill 10,20,30,40 unstalled: output 25 on frame 3 only
    lat_mode = 1;
    fill_vals = '{8'd10, 8'd20, 8'd30, 8'd40};
    for (int f = 0; f < 4; f++) begin
      send_frame(const_frame(fill_vals[f]), 0, -1, -1);
      if (f == 2) check_eq("fill_done_f2", 32'(fill_done), 32'd0);
    end
    check_eq("fill_done", 32'(fill_done), 32'd1);

    // RUN with new=50 against aged 10 -> 35
    send_frame(const_frame(8'd50), 0, -1, -1);

    // Bad s_new_tlast on beat 2
    check_eq("err_pre", 32'(err_tlast), 32'(exp_err));
    send_frame(rand_frame(), 0, 2, -1);

    // Output stalls and input gaps
    lat_mode = 0;
    rnd_ready = 1;
    for (int f = 0; f < 6; f++) send_frame(rand_frame(), 2, -1, -1);
    rnd_ready = 0;
    wait_drain();
    check_eq("err_sticky", 32'(err_tlast), 32'd1);

    // Flush at RUN beat 1, then refill with 1,2,2,2 (sum 7)
    lat_mode = 1;
    send_frame(rand_frame(), 0, -1, 1);
    hist.delete();
    fill_vals = '{8'd1, 8'd2, 8'd2, 8'd2};
    for (int f = 0; f < 4; f++) begin
      send_frame(const_frame(fill_vals[f]), 0, -1, -1);
      if (f == 0) check_eq("fill_done_flushed", 32'(fill_done), 32'd0);
    end
    wait_drain();

    // Flush at an idle frame boundary applies immediately; then reset mid fill frame 3
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    hist.delete();
    for (int f = 0; f < 3; f++) send_frame(const_frame(8'd99), 0, -1, -1);
    drive_beat(16'h6363, 16'h0000, 1'b0, 1'b0, 0);
    drive_beat(16'h6363, 16'h0000, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    check_eq("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("mid_rst_tready", 32'(s_new_tready), 32'd0);
    check_eq("mid_rst_err", 32'(err_tlast), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist.delete();
    for (int f = 0; f < 4; f++) send_frame(const_frame(8'd7), 0, -1, -1);
    wait_drain();
    check_eq("final_err", 32'(err_tlast), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
